uart_rx_stream: RTL and testbench
=================================

// Module: uart_rx_stream
// PURPOSE
//  Synthesizable 8N1 UART receiver with byte FIFO; consumes the ser_tx line driven by the picosoc UART.
//  Sits directly downstream of ser_tx: replaces the bench's behavioural serial decoder and feeds a
//  valid/ready byte stream to a checker or host-side logic. Detects framing errors and FIFO overrun.
// PARAMETERS
//  CLK_DIV     106  clk cycles per bit (>=8); mid-bit sample point at CLK_DIV/2 (integer division)
//  FIFO_DEPTH  16   byte FIFO entries; power of two, >=2
// PORTS
//  clk         in   1   system clock; all logic on posedge
//  resetn      in   1   asynchronous active-low reset
//  ser_rx      in   1   serial line, idle high, asynchronous to clk
//  rd_data     out  8   FIFO head byte; valid only while rd_valid=1
//  rd_valid    out  1   FIFO non-empty
//  rd_ready    in   1   consumer accept; pop when rd_valid&&rd_ready
//  fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy
//  frame_err   out  1   one-cycle pulse: stop bit sampled low
//  overrun     out  1   one-cycle pulse: byte dropped, FIFO full
//  parity_err  out  1   one-cycle pulse: parity mismatch (constant 0 without UART_RX_PARITY_EN)
// BEHAVIOUR
//  - Reset: sync flops=1, state=IDLE, counters=0, FIFO empty; rd_valid=0, rd_data=0, fifo_count=0,
//    frame_err=overrun=parity_err=0. Reset mid-frame abandons the frame; nothing is pushed.
//  - ser_rx passes a 2-flop synchronizer (reset value 1); all decisions use the synced value.
//  - FSM: IDLE -> START on synced 1->0. START: wait CLK_DIV/2 cycles, sample; 1 -> IDLE (glitch, no
//    flag), 0 -> DATA. DATA: 8 samples every CLK_DIV cycles, LSB first, shift right into rx_byte.
//    [PARITY] -> STOP: sample after CLK_DIV. Stop=1 -> push, IDLE. Stop=0 -> frame_err, discard,
//    BREAK. BREAK: wait for synced line=1, then IDLE (no new start detected during a break).
//  - Bit counter: 0..CLK_DIV-1, reloads on each sample; no drift across the frame.
//  - Push occurs in the cycle after the stop sample; byte visible on rd_data one cycle later.
//    Latency falling-edge-at-pin to rd_valid: 2 (sync) + CLK_DIV/2 + 9*CLK_DIV + 2 cycles.
//  - FIFO full at push: byte dropped, overrun pulses, contents unchanged. Full with pop in the same
//    cycle: push accepted, no overrun, count unchanged.
//  - Empty: rd_ready ignored, count stays 0. Pop and push same cycle when non-empty: count unchanged.
//  - Pointers wrap modulo FIFO_DEPTH; count width holds FIFO_DEPTH exactly.
//  - Error pulses never coincide with push of the failing byte; at most one error flag per frame.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: 8E1 frame; PARITY state samples one bit after data; even-parity
//    mismatch -> parity_err pulse, byte discarded, stop bit still sampled (frame_err takes precedence
//    if stop=0). Latency gains CLK_DIV cycles.
//  Undefined: 8N1, no PARITY state, parity_err tied to 0.
// STRUCTURE
//  Package uart_rx_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK), localparams
//    for data width 8 and synchronizer depth 2.
//  Sub-module uart_byte_fifo (DEPTH param; push/pop/full/empty/count) instantiated once; FSM,
//    synchronizer and bit timing stay in uart_rx_stream.
// TESTING (CLK_DIV=106, FIFO_DEPTH=16)
//  1. Drive 0x55 then 0xA3 at 106 clk/bit, rd_ready=1 -> rd_data 0x55 then 0xA3, no error pulses.
//  2. 40-cycle low glitch on idle line -> no push, no flags, FSM back in IDLE, next byte 0x41 received.
//  3. Send 0x7E with stop bit forced 0, line held low 300 cycles -> one frame_err, FIFO empty;
//     following 0x31 received correctly.
//  4. rd_ready=0, send 17 bytes 0x00..0x10 -> count=16, one overrun on 17th; drain yields 0x00..0x0F.
//  5. FIFO full, assert rd_ready in the push cycle of a new byte -> no overrun, count stays 16,
//     new byte appears last.
//  6. resetn low mid-DATA of 0xC3 -> outputs reset values; after release next byte 0x5A only in FIFO.
//     With UART_RX_PARITY_EN: 0x5A with parity bit 1 -> parity_err, no push.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive stream.
// Parity support is selected in uart_rx_stream with the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

   localparam int unsigned DataWidth = 8;
   localparam int unsigned SyncDepth = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO for the UART receiver. A pop frees a slot in the same cycle, so a push
// into a full FIFO is accepted when it coincides with a pop.
module uart_byte_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        push,
   input  logic [WIDTH-1:0]            wdata,
   input  logic                        pop,
   output logic [WIDTH-1:0]            rdata,
   output logic                        empty,
   output logic [$clog2(DEPTH+1)-1:0]  count,
   output logic                        overrun
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CntW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head byte is forced to zero while empty so stale storage never leaks out.
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= push && !do_push;
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver feeding a valid/ready byte stream through a FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_stream
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 106,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             ser_rx,
   output logic [DataWidth-1:0]             rd_data,
   output logic                             rd_valid,
   input  logic                             rd_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
   output logic                             frame_err,
   output logic                             overrun,
   output logic                             parity_err
);
   localparam int unsigned BitW = $clog2(CLK_DIV);
   localparam logic [BitW-1:0] HalfLast = BitW'(CLK_DIV / 2 - 1);
   localparam logic [BitW-1:0] FullLast = BitW'(CLK_DIV - 1);

   logic [SyncDepth-1:0] sync;
   logic                 rx;
   state_t               state;
   logic [BitW-1:0]      bit_cnt;
   logic [2:0]           bit_idx;
   logic [DataWidth-1:0] rx_byte;
   logic                 push;
   logic                 tick;
   logic                 empty;

   assign rx   = sync[SyncDepth-1];
   // The start state samples at mid-bit; every later sample is a full bit period on.
   assign tick = (state == StStart) ? (bit_cnt == HalfLast) : (bit_cnt == FullLast);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sync <= '1;
      else         sync <= {sync[SyncDepth-2:0], ser_rx};
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= StIdle;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         rx_byte    <= '0;
         push       <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         push      <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (state inside {StStart, StData, StParity, StStop}) begin
            bit_cnt <= tick ? '0 : bit_cnt + 1'b1;
         end
         case (state)
            StIdle: begin
               if (!rx) begin
                  state   <= StStart;
                  bit_cnt <= '0;
               end
            end
            StStart: begin
               if (tick) begin
                  state   <= rx ? StIdle : StData;
                  bit_idx <= '0;
               end
            end
            StData: begin
               if (tick) begin
                  rx_byte <= {rx, rx_byte[DataWidth-1:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'(DataWidth - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state <= StParity;
`else
                     state <= StStop;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (tick) begin
                  par_bad <= (^rx_byte) != rx;
                  state   <= StStop;
               end
            end
`endif
            StStop: begin
               if (tick) begin
                  if (!rx) begin
                     frame_err <= 1'b1;
                     state     <= StBreak;
`ifdef UART_RX_PARITY_EN
                  end else if (par_bad) begin
                     parity_err <= 1'b1;
                     state      <= StIdle;
`endif
                  end else begin
                     push  <= 1'b1;
                     state <= StIdle;
                  end
               end
            end
            StBreak: begin
               if (rx) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DataWidth)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (push),
      .wdata   (rx_byte),
      .pop     (rd_ready),
      .rdata   (rd_data),
      .empty   (empty),
      .count   (fifo_count),
      .overrun (overrun)
   );

   assign rd_valid = !empty;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboard bench for uart_rx_stream: frames are driven on ser_rx and their expected
// outcome (byte, frame error, parity error, overrun) is queued for an independent monitor.
`timescale 1ns/1ps
module tb_uart_rx_stream;
   localparam int unsigned CLK_DIV    = 106;
   localparam int unsigned FIFO_DEPTH = 16;
   localparam int unsigned HALF       = CLK_DIV / 2;
   localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
`ifdef UART_RX_PARITY_EN
   localparam int unsigned FRAME_BITS = 10;
`else
   localparam int unsigned FRAME_BITS = 9;
`endif
   // Falling edge at the pin to the FIFO write edge, from the stated rd_valid latency minus one.
   localparam int unsigned PUSH_EDGE = 2 + HALF + FRAME_BITS * CLK_DIV + 1;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          ser_rx = 1'b1;
   logic          rd_ready = 1'b0;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic [CW-1:0] fifo_count;
   logic          frame_err;
   logic          overrun;
   logic          parity_err;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_fe = 0, exp_ov = 0, exp_pe = 0;
   int got_fe = 0, got_ov = 0, got_pe = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   always #5 clk = ~clk;

   uart_rx_stream #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .ser_rx     (ser_rx),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .fifo_count (fifo_count),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   // Monitor: count error pulses and compare every accepted byte against the queue.
   always @(negedge clk) begin
      if (resetn) begin
         if (frame_err)  got_fe++;
         if (overrun)    got_ov++;
         if (parity_err) got_pe++;
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rd_data);
            end else begin
               mon_exp = exp_q.pop_front();
               check("rd_data", {24'd0, rd_data}, {24'd0, mon_exp});
            end
         end
      end
   end

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic bit_time();
      repeat (CLK_DIV) @(posedge clk);
      #1;
   endtask

   // Drive one frame; the model decides its fate before the stop bit is sampled.
   task automatic send_frame(input logic [7:0] data, input bit bad_stop, input bit flip_par,
                             input bit timed_pop);
      @(posedge clk);
      #1 ser_rx = 1'b0;
      if (timed_pop) begin
         fork
            begin
               repeat (PUSH_EDGE) @(posedge clk);
               #1 rd_ready = 1'b1;
               @(posedge clk);
               #1 rd_ready = 1'b0;
            end
         join_none
      end
      bit_time();
      for (int i = 0; i < 8; i++) begin
         ser_rx = data[i];
         bit_time();
      end
`ifdef UART_RX_PARITY_EN
      ser_rx = (^data) ^ flip_par;
      bit_time();
`endif
      ser_rx = !bad_stop;
      if (bad_stop) exp_fe++;
`ifdef UART_RX_PARITY_EN
      else if (flip_par) exp_pe++;
`endif
      else if (exp_q.size() >= FIFO_DEPTH && !timed_pop) exp_ov++;
      else exp_q.push_back(data);
      bit_time();
      if (bad_stop) begin
         repeat (300) @(posedge clk);
         #1;
      end
      ser_rx = 1'b1;
      bit_time();
   endtask

   task automatic wait_drain(input string name);
      int budget = 4 * CLK_DIV;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_flags(input string name);
      check({name, "_frame_err_cnt"}, got_fe, exp_fe);
      check({name, "_overrun_cnt"}, got_ov, exp_ov);
      check({name, "_parity_err_cnt"}, got_pe, exp_pe);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_fifo_count", fifo_count, 0);
      check("reset_flags", {frame_err, overrun, parity_err}, 0);
      resetn = 1'b1;
      rd_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // Two back-to-back bytes
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
      wait_drain("basic");
      check_flags("basic");

      // Short low glitch must not start a frame
      ser_rx = 1'b0;
      repeat (40) @(posedge clk);
      #1 ser_rx = 1'b1;
      repeat (2 * CLK_DIV) @(posedge clk);
      #1;
      check("glitch_count", fifo_count, 0);
      send_frame(8'h41, 1'b0, 1'b0, 1'b0);
      wait_drain("glitch");
      check_flags("glitch");

      // Framing error followed by a break, then recovery
      send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
      check("frame_err_fifo_empty", fifo_count, 0);
      send_frame(8'h31, 1'b0, 1'b0, 1'b0);
      wait_drain("frame");
      check_flags("frame");

      // Fill past capacity with the consumer stalled
      rd_ready = 1'b0;
      for (int b = 0; b <= 16; b++) send_frame(8'(b), 1'b0, 1'b0, 1'b0);
      check("full_count", fifo_count, FIFO_DEPTH);
      check("full_rd_valid", rd_valid, 1);
      check_flags("overrun");

      // Pop in the very cycle of a push into a full FIFO
      send_frame(8'hE7, 1'b0, 1'b0, 1'b1);
      check("full_pop_push_count", fifo_count, FIFO_DEPTH);
      check_flags("pop_push");
      rd_ready = 1'b1;
      wait_drain("overrun");
      check("drained_count", fifo_count, 0);

      // Reset in the middle of the data bits
      @(posedge clk);
      #1 ser_rx = 1'b0;
      bit_time();
      for (int i = 0; i < 4; i++) begin
         ser_rx = 1'(8'hC3 >> i);
         bit_time();
      end
      resetn = 1'b0;
      ser_rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midreset_rd_valid", rd_valid, 0);
      check("midreset_fifo_count", fifo_count, 0);
      check("midreset_flags", {frame_err, overrun, parity_err}, 0);
      resetn = 1'b1;
      repeat (2 * CLK_DIV) @(posedge clk);
      #1;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      wait_drain("midreset");
`ifdef UART_RX_PARITY_EN
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      wait_drain("parity");
`endif
      check_flags("midreset");

      // Randomised frames
      for (int n = 0; n < 14; n++) begin
         logic [7:0] d = 8'($urandom);
         bit bs = ($urandom_range(0, 7) == 0);
         bit fp = ($urandom_range(0, 3) == 0);
         send_frame(d, bs, fp, 1'b0);
         repeat ($urandom_range(0, 50)) @(posedge clk);
         #1;
      end
      wait_drain("random");
      check_flags("random");
      check("final_count", fifo_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
